muldiv_wb_unit: RTL and testbench

Iterative multi-cycle unsigned multiply/divide unit that sits directly downstream of the RegisterFile read ports.
- Consumes R_Data_A/R_Data_B operands and a destination address.
- Computes one result bit per cycle.
- Drives the RegisterFile write port (Write_Reg, W_Addr, W_Data) for exactly one cycle at completion.
- Keeps long-latency arithmetic out of the single-cycle ALU path.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_datapath.sv | 76 +++++++
 rtl/muldiv_wb_unit.sv | 122 ++++++++++++
 tb/tb_muldiv_wb_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings shared by the iterative mul/div unit.
// Optional macro MULDIV_EARLY_OUT_EN enables early exit for multiplies.
package muldiv_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        OP_MUL   = 2'd0,
        OP_MULHU = 2'd1,
        OP_DIVU  = 2'd2,
        OP_REMU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    function automatic logic is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift-add multiplier and restoring divider, one bit per step.
// Optional macro MULDIV_EARLY_OUT_EN exposes the multiplier-exhausted flag.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic                div_mode,
    input  logic [DATA_W-1:0]   src_a,
    input  logic [DATA_W-1:0]   src_b,
    output logic [2*DATA_W-1:0] product,
    output logic [DATA_W-1:0]   quotient,
    output logic [DATA_W-1:0]   remainder
`ifdef MULDIV_EARLY_OUT_EN
    ,
    output logic                mplier_zero
`endif
);

    logic [2*DATA_W-1:0] prod_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   opb_q;
    logic [DATA_W-1:0]   quot_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     rem_diff;
    logic                rem_ge;

    // rem_q < divisor always, so a borrow shows up in the top diff bit
    always_comb begin
        rem_shift = {rem_q, quot_q[DATA_W-1]};
        rem_diff  = rem_shift - {1'b0, opb_q};
        rem_ge    = ~rem_diff[DATA_W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_q  <= '0;
            mcand_q <= '0;
            opb_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else if (load) begin
            prod_q  <= '0;
            mcand_q <= {{DATA_W{1'b0}}, src_a};
            opb_q   <= src_b;
            quot_q  <= src_a;
            rem_q   <= '0;
        end else if (step) begin
            if (div_mode) begin
                rem_q  <= rem_ge ? rem_diff[DATA_W-1:0]
                                 : rem_shift[DATA_W-1:0];
                quot_q <= {quot_q[DATA_W-2:0], rem_ge};
            end else begin
                if (opb_q[0]) begin
                    prod_q <= prod_q + mcand_q;
                end
                mcand_q <= mcand_q << 1;
                opb_q   <= opb_q >> 1;
            end
        end
    end

    assign product   = prod_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

`ifdef MULDIV_EARLY_OUT_EN
    assign mplier_zero = (opb_q == '0);
`endif

endmodule

// File: rtl/muldiv_wb_unit.sv
// muldiv_wb_unit: FSM, iteration counter and RegisterFile write-port registers.
// Optional macro MULDIV_EARLY_OUT_EN ends multiplies once the multiplier is spent.
module muldiv_wb_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic              Write_Reg,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data
);

    state_e              state;
    logic [CNT_W-1:0]    cnt;
    op_e                 op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   quotient;
    logic [DATA_W-1:0]   remainder;
    logic [DATA_W-1:0]   result;
    logic                load;
    logic                step;
    logic                last;

    assign load = (state == ST_IDLE) && start;
    assign step = (state == ST_CALC) && !last;

`ifdef MULDIV_EARLY_OUT_EN
    logic mplier_zero;
    assign last = (cnt == CNT_W'(DATA_W)) || (!is_div(op_q) && mplier_zero);
`else
    assign last = (cnt == CNT_W'(DATA_W));
`endif

    muldiv_datapath #(
        .DATA_W (DATA_W)
    ) u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .div_mode  (is_div(op_q)),
        .src_a     (src_a),
        .src_b     (src_b),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef MULDIV_EARLY_OUT_EN
        ,
        .mplier_zero (mplier_zero)
`endif
    );

    always_comb begin
        result = '0;
        unique case (op_q)
            OP_MUL:   result = product[DATA_W-1:0];
            OP_MULHU: result = product[2*DATA_W-1:DATA_W];
            OP_DIVU:  result = quotient;
            OP_REMU:  result = remainder;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= OP_MUL;
            rd_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            Write_Reg <= 1'b0;
            W_Addr    <= '0;
            W_Data    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_CALC;
                        cnt   <= '0;
                        op_q  <= op_e'(op);
                        rd_q  <= rd_addr;
                        busy  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (last) begin
                        state     <= ST_WB;
                        done      <= 1'b1;
                        Write_Reg <= (rd_q != '0);
                        // x0 is never written; port keeps its last value
                        if (rd_q != '0) begin
                            W_Addr <= rd_q;
                            W_Data <= result;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WB: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    Write_Reg <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_wb_unit.sv
// tb_muldiv_wb_unit: directed and random ops checked against an arithmetic model.
// Built without MULDIV_EARLY_OUT_EN, so every op has fixed latency.
module tb_muldiv_wb_unit;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = '0;
    logic [DW-1:0] src_a = '0;
    logic [DW-1:0] src_b = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          busy;
    logic          done;
    logic          Write_Reg;
    logic [AW-1:0] W_Addr;
    logic [DW-1:0] W_Data;

    int n_chk = 0;
    int n_pass = 0;

    logic [DW-1:0] exp_wdata = '0;
    logic [AW-1:0] exp_waddr = '0;

    muldiv_wb_unit #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .CNT_W  (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .rd_addr   (rd_addr),
        .busy      (busy),
        .done      (done),
        .Write_Reg (Write_Reg),
        .W_Addr    (W_Addr),
        .W_Data    (W_Data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] model(input logic [1:0] o,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [2*DW-1:0] p;
        p = 64'(a) * 64'(b);
        case (o)
            2'd0:    return p[DW-1:0];
            2'd1:    return p[2*DW-1:DW];
            2'd2:    return (b == 0) ? '1 : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // inj: cycle index after the accepting edge at which a stray start is driven
    task automatic run_op(input logic [1:0] o, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [AW-1:0] rd,
                          input int inj);
        logic [DW-1:0] res;
        logic [DW-1:0] wd;
        logic [AW-1:0] wa;
        logic          wr_at_done;
        int lat, busy_n, done_n, wr_n;
        bit fin;
        res = model(o, a, b);
        lat = -1; busy_n = 0; done_n = 0; wr_n = 0; fin = 0;
        wd = '0; wa = '0; wr_at_done = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; rd_addr = rd;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); src_a = $urandom; src_b = $urandom;
        rd_addr = 5'($urandom);
        if (busy) busy_n++;
        for (int k = 1; k <= 60 && !fin; k++) begin
            if (k == inj) begin
                start = 1'b1; op = 2'($urandom);
                src_a = $urandom; src_b = $urandom;
                rd_addr = 5'($urandom_range(1, 31));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (busy) busy_n++;
            if (Write_Reg) wr_n++;
            if (done) begin
                done_n++;
                lat = k; wd = W_Data; wa = W_Addr; wr_at_done = Write_Reg;
            end
            if (done_n > 0 && !busy) fin = 1;
        end
        start = 1'b0;
        if (rd != 0) begin
            exp_wdata = res;
            exp_waddr = rd;
        end
        check("finished", 64'(fin), 64'd1);
        check("done_pulses", 64'(done_n), 64'd1);
        check("latency", 64'(lat), 64'(DW + 1));
        check("busy_cycles", 64'(busy_n), 64'(DW + 2));
        check("write_pulses", 64'(wr_n), 64'(rd != 0));
        check("write_at_done", 64'(wr_at_done), 64'(rd != 0));
        check("w_data", 64'(wd), 64'(exp_wdata));
        check("w_addr", 64'(wa), 64'(exp_waddr));
    endtask

    initial begin
        int cnt_bad;
        logic [DW-1:0] rb;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wr", 64'(Write_Reg), 64'd0);
        check("rst_waddr", 64'(W_Addr), 64'd0);
        check("rst_wdata", 64'(W_Data), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        run_op(2'd0, 32'h12345678, 32'h00000010, 5'd1, 0);
        run_op(2'd1, 32'h12345678, 32'h00000010, 5'd2, 0);
        run_op(2'd2, 32'h87654321, 32'h00000010, 5'd31, 0);
        run_op(2'd3, 32'h87654321, 32'h00000010, 5'd21, 0);
        run_op(2'd2, 32'h9890ACFE, 32'h00000000, 5'd7, 0);
        run_op(2'd3, 32'h9890ACFE, 32'h00000000, 5'd8, 0);
        run_op(2'd0, 32'hDEADBEEF, 32'h00000003, 5'd9, 6);
        run_op(2'd2, 32'hFFFFFFFF, 32'h00000001, 5'd10, 34);
        run_op(2'd0, 32'h0000FFFF, 32'h0000FFFF, 5'd0, 0);
        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 0);

        // reset mid-multiply
        @(negedge clk);
        start = 1'b1; op = 2'd0; src_a = 32'hCAFEF00D; src_b = 32'h12345;
        rd_addr = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_wr", 64'(Write_Reg), 64'd0);
        check("arst_wdata", 64'(W_Data), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        exp_wdata = '0;
        exp_waddr = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cnt_bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (Write_Reg || done || busy) cnt_bad++;
        end
        check("no_wb_after_rst", 64'(cnt_bad), 64'd0);
        run_op(2'd0, 32'hCAFEF00D, 32'h00012345, 5'd4, 0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            run_op(2'($urandom_range(0, 3)), $urandom, rb,
                   5'($urandom_range(0, 31)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 34)) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
